// File: rtl/traffic_light_monitor.sv
// Passive checker for red->green->yellow order and exact enabled-cycle phase lengths.
// Latency 1 cycle: outputs are registered from the sample taken at the same edge. No backpressure.
module traffic_light_monitor #(
   parameter int RED_LEN    = 32,
   parameter int GREEN_LEN  = 20,
   parameter int YELLOW_LEN = 7,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   output logic             locked,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] phase_cnt,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [7:0]       err_count,
   output logic             cycle_done
);

   typedef enum logic [1:0] {
      S_SYNC   = 2'd0,
      S_RED    = 2'd1,
      S_GREEN  = 2'd2,
      S_YELLOW = 2'd3
   } phase_t;

   localparam logic [2:0] L_RED    = 3'b100;
   localparam logic [2:0] L_GREEN  = 3'b010;
   localparam logic [2:0] L_YELLOW = 3'b001;

   localparam logic [2:0] E_NONE     = 3'd0;
   localparam logic [2:0] E_ILLEGAL  = 3'd1;
   localparam logic [2:0] E_ORDER    = 3'd2;
   localparam logic [2:0] E_SHORT    = 3'd3;
   localparam logic [2:0] E_LONG     = 3'd4;
   localparam logic [2:0] E_DISABLED = 3'd5;

   phase_t           state_q;
   phase_t           state_d;
   phase_t           succ_state;
   logic [2:0]       lights;
   logic [2:0]       prev_lights;
   logic [2:0]       succ_light;
   logic [2:0]       ecode;
   logic [CNT_W-1:0] cur_len;
   logic [CNT_W-1:0] cnt_d;
   logic             done_d;
   logic             legal;

   assign lights = {red, green, yellow};
   assign legal  = (lights == L_RED) || (lights == L_GREEN) || (lights == L_YELLOW);

   // Required length of the current phase and the light that must follow it.
   always_comb begin
      cur_len    = CNT_W'(RED_LEN);
      succ_light = L_GREEN;
      succ_state = S_GREEN;
      case (state_q)
         S_GREEN: begin
            cur_len    = CNT_W'(GREEN_LEN);
            succ_light = L_YELLOW;
            succ_state = S_YELLOW;
         end
         S_YELLOW: begin
            cur_len    = CNT_W'(YELLOW_LEN);
            succ_light = L_RED;
            succ_state = S_RED;
         end
         default: ;
      endcase
   end

   // The if/else chain order encodes error priority 1 > 5 > 2 > 3 > 4.
   always_comb begin
      state_d = state_q;
      cnt_d   = phase_cnt;
      ecode   = E_NONE;
      done_d  = 1'b0;
      if (!legal) begin
         ecode = E_ILLEGAL;
      end else if (state_q == S_SYNC) begin
         if (lights == L_RED && prev_lights != L_RED) begin
            state_d = S_RED;
            cnt_d   = CNT_W'(1);
         end
      end else if (!enable) begin
         if (lights != prev_lights) ecode = E_DISABLED;
      end else if (lights == prev_lights) begin
         if (phase_cnt == cur_len) ecode = E_LONG;
         else                      cnt_d = phase_cnt + CNT_W'(1);
      end else if (lights != succ_light) begin
         ecode = E_ORDER;
      end else if (phase_cnt != cur_len) begin
         ecode = E_SHORT;
      end else begin
         state_d = succ_state;
         cnt_d   = CNT_W'(1);
         done_d  = (state_q == S_YELLOW);
      end
      if (ecode != E_NONE) begin
         state_d = S_SYNC;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_SYNC;
         prev_lights <= 3'b000;
         phase_cnt   <= '0;
         err         <= 1'b0;
         err_code    <= E_NONE;
         err_count   <= 8'd0;
         cycle_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_lights <= lights;
         phase_cnt   <= cnt_d;
         err         <= (ecode != E_NONE);
         cycle_done  <= done_d;
         if (ecode != E_NONE) begin
            err_code <= ecode;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

   assign locked = (state_q != S_SYNC);
   assign phase  = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed plan plus randomized light sequences.
module tb_traffic_light_monitor;

   localparam int RL = 32;
   localparam int GL = 20;
   localparam int YL = 7;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       red;
   logic       yellow;
   logic       green;
   logic       locked;
   logic [1:0] phase;
   logic [7:0] phase_cnt;
   logic       err;
   logic [2:0] err_code;
   logic [7:0] err_count;
   logic       cycle_done;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .RED_LEN(RL), .GREEN_LEN(GL), .YELLOW_LEN(YL), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .red(red), .yellow(yellow), .green(green),
      .locked(locked), .phase(phase), .phase_cnt(phase_cnt),
      .err(err), .err_code(err_code), .err_count(err_count),
      .cycle_done(cycle_done)
   );

   typedef struct packed {
      logic       locked;
      logic [1:0] phase;
      logic [7:0] cnt;
      logic       err;
      logic [2:0] code;
      logic [7:0] count;
      logic       cd;
   } obs_t;

   obs_t exp_q[$];
   int   id_q[$];
   int   cd_steps[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   // Reference model: lamp index 0=red 1=green 2=yellow, successor is (idx+1) mod 3.
   bit         m_locked;
   int         m_idx;
   int         m_cnt;
   int         m_code;
   int         m_count;
   logic [2:0] m_prev;
   int         len_tab[3] = '{RL, GL, YL};
   logic [2:0] illegal_tab[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

   task automatic model_reset();
      m_locked = 0; m_idx = 0; m_cnt = 0; m_code = 0; m_count = 0; m_prev = 3'b000;
   endtask

   task automatic model_step(input bit en, input logic [2:0] l, output obs_t o);
      int e;
      int li;
      bit cd;
      e = 0;
      cd = 0;
      li = (l == 3'b100) ? 0 : (l == 3'b010) ? 1 : (l == 3'b001) ? 2 : -1;
      if (li < 0) e = 1;
      else if (!m_locked) begin
         if (li == 0 && m_prev != l) begin
            m_locked = 1; m_idx = 0; m_cnt = 1;
         end
      end
      else if (!en) begin
         if (l != m_prev) e = 5;
      end
      else if (li == m_idx) begin
         if (m_cnt == len_tab[m_idx]) e = 4;
         else m_cnt++;
      end
      else if (li != (m_idx + 1) % 3) e = 2;
      else if (m_cnt != len_tab[m_idx]) e = 3;
      else begin
         cd = (m_idx == 2); m_idx = li; m_cnt = 1;
      end
      if (e != 0) begin
         m_locked = 0; m_cnt = 0; m_code = e;
         if (m_count < 255) m_count++;
      end
      m_prev   = l;
      o.locked = m_locked;
      o.phase  = m_locked ? 2'(m_idx + 1) : 2'd0;
      o.cnt    = 8'(m_cnt);
      o.err    = (e != 0);
      o.code   = 3'(m_code);
      o.count  = 8'(m_count);
      o.cd     = cd;
   endtask

   task automatic step(input bit en, input logic [2:0] l);
      obs_t o;
      @(negedge clk);
      enable = en;
      {red, green, yellow} = l;
      step_no++;
      model_step(en, l, o);
      exp_q.push_back(o);
      id_q.push_back(step_no);
   endtask

   task automatic phase_run(input int idx, input int n, input bit en = 1'b1);
      logic [2:0] l;
      l = 3'b100 >> idx;
      repeat (n) step(en, l);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_phase"}, int'(phase), 0);
      chk({tag, "_phase_cnt"}, int'(phase_cnt), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_err_code"}, int'(err_code), 0);
      chk({tag, "_err_count"}, int'(err_count), 0);
      chk({tag, "_cycle_done"}, int'(cycle_done), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      enable = 1'b0;
      {red, green, yellow} = 3'b000;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic random_phases(input int nphase);
      int idx;
      int n;
      int r;
      int done;
      bit en;
      logic [2:0] l;
      for (int p = 0; p < nphase; p++) begin
         idx = p % 3;
         n = len_tab[idx];
         r = $urandom_range(0, 9);
         if (r == 0) n = n - 1;
         else if (r == 1) n = n + 1;
         done = 0;
         while (done < n) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) l = illegal_tab[$urandom_range(0, 4)];
            else l = 3'b100 >> idx;
            step(en, l);
            if (en) done++;
         end
      end
   endtask

   // Monitor: compares every registered output sample against the model's prediction.
   initial begin
      obs_t e;
      obs_t a;
      int   id;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = '{locked, phase, phase_cnt, err, err_code, err_count, cycle_done};
            checks++;
            if (a.cd) cd_steps.push_back(id);
            if (a !== e) begin
               errors++;
               $display("FAIL seq step %0d: got lk=%0d ph=%0d cnt=%0d err=%0d code=%0d count=%0d cd=%0d, expected lk=%0d ph=%0d cnt=%0d err=%0d code=%0d count=%0d cd=%0d",
                        id, a.locked, a.phase, a.cnt, a.err, a.code, a.count, a.cd,
                        e.locked, e.phase, e.cnt, e.err, e.code, e.count, e.cd);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      red = 1'b0; yellow = 1'b0; green = 1'b0;
      do_reset();
      chk_all_zero("reset");

      // 1: ideal controller for 130 cycles
      step(1, 3'b100);
      settle();
      chk("lock_after_first_red", int'(locked), 1);
      phase_run(0, RL - 1); phase_run(1, GL); phase_run(2, YL);
      phase_run(0, RL);     phase_run(1, GL); phase_run(2, YL);
      phase_run(0, 12);
      settle();
      chk("cd_pulses", cd_steps.size(), 2);
      chk("cd_first_step", (cd_steps.size() > 0) ? cd_steps[0] : -1, 60);
      chk("cd_second_step", (cd_steps.size() > 1) ? cd_steps[1] : -1, 119);
      chk("ideal_err_count", int'(err_count), 0);

      // 2: short green
      phase_run(0, RL - 12);
      phase_run(1, GL - 1);
      step(1, 3'b001);
      settle();
      chk("short_err", int'(err), 1);
      chk("short_code", int'(err_code), 3);
      chk("short_count", int'(err_count), 1);
      chk("short_phase", int'(phase), 0);
      phase_run(2, 6);
      step(1, 3'b100);
      settle();
      chk("relock", int'(locked), 1);
      chk("relock_cnt", int'(phase_cnt), 1);

      // 3: long yellow
      phase_run(0, RL - 1); phase_run(1, GL); phase_run(2, YL);
      step(1, 3'b001);
      settle();
      chk("long_code", int'(err_code), 4);
      chk("long_locked", int'(locked), 0);

      // 4: order violation, then illegal pattern outranking change-while-disabled
      phase_run(0, RL);
      step(1, 3'b001);
      settle();
      chk("order_code", int'(err_code), 2);
      phase_run(0, 5);
      step(0, 3'b110);
      settle();
      chk("illegal_code", int'(err_code), 1);

      // 5: enable drop mid-green, then a change while disabled
      phase_run(0, RL);
      phase_run(1, 5);
      phase_run(1, 10, 1'b0);
      settle();
      chk("hold_cnt", int'(phase_cnt), 5);
      chk("hold_count", int'(err_count), 4);
      phase_run(1, GL - 5); phase_run(2, YL);
      step(1, 3'b100);
      settle();
      chk("resume_cd", int'(cycle_done), 1);
      phase_run(0, 2);
      step(0, 3'b010);
      settle();
      chk("disabled_code", int'(err_code), 5);
      chk("disabled_count", int'(err_count), 5);

      random_phases(24);

      // 6: saturation and asynchronous reset
      repeat (300) step(1, illegal_tab[$urandom_range(0, 4)]);
      settle();
      chk("sat_count", int'(err_count), 255);
      repeat (3) step(1, 3'b111);
      @(posedge clk);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      chk_all_zero("async_reset");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      phase_run(0, RL); phase_run(1, GL); phase_run(2, YL); phase_run(0, 3);
      settle();
      chk("final_count", int'(err_count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker for the traffic_light controller output; samples red/yellow/green and enable on every clk edge.
- Locks onto the light sequence and checks phase order (red -> green -> yellow -> red) and exact phase durations.
- Reports each violation as an error pulse, an error code and a saturating error count.
- Instantiated beside traffic_light in system benches and as an on-chip sanity monitor.

Parameters:
- RED_LEN, 32, required enabled-cycle length of the red phase
- GREEN_LEN, 20, required enabled-cycle length of the green phase
- YELLOW_LEN, 7, required enabled-cycle length of the yellow phase
- CNT_W, 8, width of the phase counter; must hold max(*_LEN)+1

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  same enable as driven into the controller
- red  input  1  observed red lamp
- yellow  input  1  observed yellow lamp
- green  input  1  observed green lamp
- locked  output  1  high while the monitor is tracking a valid sequence
- phase  output  2  0=SYNC, 1=RED, 2=GREEN, 3=YELLOW
- phase_cnt  output  CNT_W  enabled cycles the current light has been observed, including the current sample
- err  output  1  one-cycle pulse on a detected violation
- err_code  output  3  code of the last error, held until the next error
- err_count  output  8  errors since reset, saturates at 255
- cycle_done  output  1  one-cycle pulse on each complete, correct red-green-yellow cycle

Behaviour:
- Reset values: all outputs 0, phase=SYNC. Internal prev_lights register = 3'b000.
- All outputs are registered and reflect the sample taken at the same edge, so latency is 1 cycle from the input change.
- prev_lights updates every edge regardless of enable.
- Illegal pattern (lights not one-hot) is checked in every state. It gives code 1.
- SYNC:
  - No order or length checks.
  - Red sampled with prev_lights != red: enter RED, phase_cnt=1, locked=1.
  - A reset followed by red is therefore an entry.
- Locked state, enable=1, same light as the previous sample:
  - If phase_cnt == LEN of the phase, flag code 4 (long phase).
  - Otherwise increment phase_cnt.
- Locked state, enable=1, different legal light:
  - Wrong successor: code 2 (order).
  - Correct successor but phase_cnt != LEN of the old phase: code 3 (short phase).
  - Otherwise enter the next phase with phase_cnt=1.
  - Yellow -> red transition with all checks passing also pulses cycle_done.
- Locked state, enable=0:
  - phase_cnt holds.
  - Any change of the lights gives code 5 (change while disabled).
- Error priority within one sample: 1 > 5 > 2 > 3 > 4.
- On any error:
  - err=1 for one cycle and err_code is loaded.
  - err_count increments, saturating at 255.
  - phase -> SYNC, locked=0, phase_cnt=0.
  - The erroring sample cannot itself act as the SYNC entry; re-lock needs a later red entry.
- A red-with-red-prev sample in SYNC does not lock. The monitor waits for a fresh red edge.
- Reset mid-sequence: immediate return to reset values, including err_count.

Test Plan:
1. Reset, then enable=1 with the lights driven as an ideal controller (red 32, green 20, yellow 7) for 130 cycles.
   - locked=1 the cycle after the first red sample.
   - cycle_done pulses at the first red re-entry and again 59 cycles later.
   - err never asserts, err_count=0.
2. Shorten green to 19 cycles.
   - On the yellow sample: err pulse, err_code=3, err_count=1, phase=SYNC.
   - Re-lock at the next red entry.
3. Hold yellow for 8 cycles.
   - err with err_code=4 on the 8th yellow sample, locked=0.
4. Drive red -> yellow directly after 32 red cycles.
   - err_code=2.
   - Separately drive red=green=1 for one cycle: err_code=1 (priority over any other code).
5. After lock, drop enable for 10 cycles mid-green.
   - phase_cnt holds, no error, and the sequence resumes correctly.
   - Then toggle a light while enable=0: err_code=5.
6. Force 300 consecutive illegal samples.
   - err_count saturates at 255.
   - Assert reset mid-stream: all outputs return to 0 asynchronously.
